serial_to_parallel_loader: RTL
==============================

// Module: serial_to_parallel_loader
// PURPOSE
//   Deserialiser stage that feeds the 8-bit register bank.
//   - Collects a framed serial bit stream into a WIDTH-bit word.
//   - Presents the word on par_out with a one-cycle par_valid strobe.
//   - par_out drives the register's data input; par_valid serves as its load qualifier.
// PARAMETERS
//   WIDTH      8   word length in bits (>= 2)
//   MSB_FIRST  0   0: first serial bit -> par_out[0]; 1: first serial bit -> par_out[WIDTH-1]
// PORTS
//   clk        in   1      system clock, all state updates on rising edge
//   rst        in   1      reset, asynchronous, active-low
//   start      in   1      begin a new word (sampled only in IDLE)
//   ser_in     in   1      serial data bit
//   ser_valid  in   1      ser_in carries a valid bit this cycle
//   clr_err    in   1      synchronous clear of err
//   par_out    out  WIDTH  last completed word; held until next completion
//   par_valid  out  1      one-cycle strobe: par_out updated this cycle
//   busy       out  1      1 while in SHIFT state
//   err        out  1      sticky: start asserted while busy
// BEHAVIOUR
//   Reset (rst=0, any time, async):
//   - State goes to IDLE; shift register and bit count clear to 0.
//   - par_out=0, par_valid=0, busy=0, err=0.
//   - Any partial word is discarded.
//   States:
//   - IDLE:  start=1 -> SHIFT with count=0; ser_valid ignored, incl. same cycle as start.
//   - SHIFT: busy=1. Each edge with ser_valid=1 shifts ser_in in; count+1.
//     ser_valid=0 cycles are gaps (no shift, no timeout).
//   Completion:
//   - On the edge that captures bit WIDTH-1: par_out <= full word, par_valid <= 1, state <= IDLE.
//   - Latency: par_valid is high in the cycle after the edge sampling the last bit.
//   - par_valid drops after exactly one cycle.
//   Bit order:
//   - MSB_FIRST=0 shifts right (new bit enters at [WIDTH-1]); bit k lands in par_out[k].
//   - MSB_FIRST=1 shifts left; first bit lands in par_out[WIDTH-1].
//   Back-to-back:
//   - start during the par_valid cycle is accepted (state is IDLE then).
//   - Minimum word period is WIDTH+1 cycles.
//   start while SHIFT:
//   - Ignored for sequencing; current word continues unaffected.
//   - err <= 1 and stays 1 until clr_err=1 or reset.
//   - If clr_err and a busy start coincide, err stays 1 (set wins).
//   Counter: width $clog2(WIDTH); never exceeds WIDTH-1; no wrap-around reachable.
//   par_out is never partially updated; intermediate shift contents are not visible.
// TESTING
//   1. WIDTH=8, MSB_FIRST=0: start, then ser_in 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles
//      -> par_out=8'hA5, par_valid=1 for exactly one cycle after the 8th edge, busy=0 then.
//   2. Same stream with ser_valid=0 gaps of 1-3 cycles between bits
//      -> par_out=8'hA5; no par_valid until the 8th valid bit; busy=1 throughout.
//   3. MSB_FIRST=1: start, then bits 1,0,1,1,0,0,1,0 -> par_out=8'hB2, one par_valid pulse.
//   4. start pulsed after 3 bits of 8'h3C (LSB first)
//      -> err=1; word still completes as 8'h3C; clr_err -> err=0 next cycle.
//   5. rst=0 after 4 bits of a word
//      -> immediately par_out=0, busy=0, err=0; after release, full word 8'h5A -> par_out=8'h5A.
//   6. Two words 8'hFF then 8'h00 with start in the par_valid cycle
//      -> two par_valid pulses 9 cycles apart; par_out 8'hFF then 8'h00.

Source files
------------

// File: rtl/serial_to_parallel_loader.sv
// Deserialiser for the register bank: gathers a framed serial stream into a
// WIDTH-bit word and presents it with a one-cycle load strobe.
module serial_to_parallel_loader #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ser_in,
   input  logic             ser_valid,
   input  logic             clr_err,
   output logic [WIDTH-1:0] par_out,
   output logic             par_valid,
   output logic             busy,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] par_out_q, par_out_d;
   logic             par_valid_q, par_valid_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] shifted;

   // The incoming bit enters at the end that leaves it at its final position
   // once all WIDTH bits have been collected.
   always_comb begin
      if (MSB_FIRST) begin
         shifted = {shreg_q[WIDTH-2:0], ser_in};
      end else begin
         shifted = {ser_in, shreg_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      shreg_d     = shreg_q;
      par_out_d   = par_out_q;
      par_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               count_d = '0;
               shreg_d = '0;
            end
         end
         SHIFT: begin
            if (ser_valid) begin
               shreg_d = shifted;
               if (count_q == LAST_BIT) begin
                  par_out_d   = shifted;
                  par_valid_d = 1'b1;
                  state_d     = IDLE;
                  count_d     = '0;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase

      busy_d = (state_d == SHIFT);

      // A start arriving mid-word takes priority over a coincident clear.
      if ((state_q == SHIFT) && start) begin
         err_d = 1'b1;
      end else if (clr_err) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         shreg_q     <= '0;
         par_out_q   <= '0;
         par_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         shreg_q     <= shreg_d;
         par_out_q   <= par_out_d;
         par_valid_q <= par_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign par_out   = par_out_q;
   assign par_valid = par_valid_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule
